// File: rtl/receiver_if.sv
// Receiver side-band bundle: baud tick, serial line, consumer ack and the
// received-byte outputs. The receiver uses the slave modport; whatever feeds
// the line and consumes bytes uses the master modport.
interface receiver_if;
  logic       tick_in;
  logic       rx;
  logic       rd_ack;
  logic [7:0] bus;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    output tick_in, rx, rd_ack,
    input  bus, data_valid, frame_err, overrun
  );

  modport slave (
    input  tick_in, rx, rd_ack,
    output bus, data_valid, frame_err, overrun
  );
endinterface

// File: rtl/receiver.sv
// Tick-driven UART receiver: 1 start, 8 data (LSB first), 1 stop, no parity.
// The line is double-flopped before use. A finished frame lands in a
// one-deep holding register (bus/data_valid) that the consumer clears with
// rd_ack; a frame arriving while that register is full is dropped and
// flagged as overrun unless rd_ack frees the register in the same cycle.
// Optional feature macro: RECEIVER_FRAME_CHECK_EN enables stop-bit checking
// and the sticky frame_err flag; without it frame_err is tied low and every
// frame is accepted.
module receiver #(
  parameter int TICKS_PER_BIT = 9,
  parameter int SAMPLE_TICK   = 4
) (
  input  logic       clk,
  input  logic       rst,
  receiver_if.slave  s_if
);

  localparam int            CW       = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_WRAP = CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SAMP = CW'(SAMPLE_TICK);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  // set after a bad stop bit: stay in STOP until the line returns high
  logic          r_stop_wait, w_stop_wait_nxt;
  logic          r_sync1, r_sync2;
  logic          w_rx;
  logic          w_frame_ok;
  logic [7:0]    r_bus;
  logic          r_dv;
  logic          r_ov;
`ifdef RECEIVER_FRAME_CHECK_EN
  logic          w_frame_bad;
  logic          r_frame_err;
`endif

  assign w_rx = r_sync2;

  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= s_if.rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, tick counter, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_stop_wait <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_stop_wait <= w_stop_wait_nxt;
    end
  end

  // next-state: START samples mid-bit, DATA/STOP sample once per bit period
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_shift_nxt     = r_shift;
    w_stop_wait_nxt = r_stop_wait;
    w_frame_ok      = 1'b0;
`ifdef RECEIVER_FRAME_CHECK_EN
    w_frame_bad     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt       = '0;
        w_idx_nxt       = '0;
        w_stop_wait_nxt = 1'b0;
        if (!w_rx) w_state_nxt = START;
      end
      START: begin
        if (s_if.tick_in) begin
          if (r_cnt == CNT_SAMP) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            // a high line at mid-start is a glitch, not a frame
            w_state_nxt = w_rx ? IDLE : DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_if.tick_in) begin
          if (r_cnt == CNT_WRAP) begin
            w_cnt_nxt          = '0;
            w_shift_nxt[r_idx] = w_rx;
            w_idx_nxt          = r_idx + 1'b1;
            if (r_idx == 3'd7) w_state_nxt = STOP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (r_stop_wait) begin
          if (w_rx) w_state_nxt = IDLE;
        end else if (s_if.tick_in) begin
          if (r_cnt == CNT_WRAP) begin
            w_cnt_nxt = '0;
`ifdef RECEIVER_FRAME_CHECK_EN
            if (!w_rx) begin
              w_frame_bad     = 1'b1;
              w_stop_wait_nxt = 1'b1;
            end else begin
              w_frame_ok  = 1'b1;
              w_state_nxt = IDLE;
            end
`else
            w_frame_ok  = 1'b1;
            w_state_nxt = IDLE;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // holding register: load when empty or freed by a same-cycle ack, else overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus <= 8'h00;
      r_dv  <= 1'b0;
      r_ov  <= 1'b0;
    end else begin
      if (s_if.rd_ack) begin
        r_dv <= 1'b0;
        r_ov <= 1'b0;
      end
      if (w_frame_ok) begin
        if (!r_dv || s_if.rd_ack) begin
          r_bus <= r_shift;
          r_dv  <= 1'b1;
        end else begin
          r_ov  <= 1'b1;
        end
      end
    end
  end

`ifdef RECEIVER_FRAME_CHECK_EN
  // sticky framing error; a new error wins over a same-cycle ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_frame_err <= 1'b0;
    else if (w_frame_bad) r_frame_err <= 1'b1;
    else if (s_if.rd_ack) r_frame_err <= 1'b0;
  end

  assign s_if.frame_err = r_frame_err;
`else
  assign s_if.frame_err = 1'b0;
`endif

  assign s_if.bus        = r_bus;
  assign s_if.data_valid = r_dv;
  assign s_if.overrun    = r_ov;

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: a directed table of frame/ack/glitch operations with
// fixed expectations, a mid-frame reset sequence, then random operations
// checked against a frame-level model of the holding register and flags.
module tb_receiver;
  localparam int TPB  = 9;
  localparam int TDIV = 3;   // clocks per baud tick
`ifdef RECEIVER_FRAME_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  localparam int OP_FRAME = 0;
  localparam int OP_ACK   = 1;
  localparam int OP_FALSE = 2;

  typedef struct {
    int         op;
    logic [7:0] d;
    bit         stop;
    int         ack_call;   // tick index in the frame carrying rd_ack, 0 = none
    logic [7:0] eb;
    bit         edv;
    bit         efe;
    bit         eov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [7:0] m_bus;
  bit         m_dv, m_fe, m_ov;

  receiver_if u_if ();

  receiver #(.TICKS_PER_BIT(TPB), .SAMPLE_TICK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (u_if)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [7:0] eb, input bit edv, input bit efe, input bit eov);
    cmp({nm, ".bus"},        u_if.bus,        eb);
    cmp({nm, ".data_valid"}, {7'b0, u_if.data_valid}, {7'b0, edv});
    cmp({nm, ".frame_err"},  {7'b0, u_if.frame_err},  {7'b0, efe});
    cmp({nm, ".overrun"},    {7'b0, u_if.overrun},    {7'b0, eov});
  endtask

  // one baud tick (optionally carrying rd_ack), then TDIV-1 quiet clocks
  task automatic do_tick(input bit ack);
    u_if.tick_in = 1'b1;
    u_if.rd_ack  = ack;
    @(posedge clk); #2;
    u_if.tick_in = 1'b0;
    u_if.rd_ack  = 1'b0;
    repeat (TDIV - 1) begin @(posedge clk); #2; end
  endtask

  task automatic idle_ticks(input int n);
    u_if.rx = 1'b1;
    repeat (n) do_tick(1'b0);
  endtask

  task automatic pulse_ack();
    u_if.rd_ack = 1'b1;
    @(posedge clk); #2;
    u_if.rd_ack = 1'b0;
  endtask

  // drive a full frame; abort_bit >= 0 pulses rst partway through that bit
  task automatic send_frame(input logic [7:0] d, input bit stop, input int ack_call, input int abort_bit);
    logic [9:0] bits;
    int call;
    bits = {stop, d, 1'b0};
    call = 0;
    for (int b = 0; b < 10; b++) begin
      u_if.rx = bits[b];
      for (int t = 0; t < TPB; t++) begin
        call++;
        if (b == abort_bit && t == 4) begin
          rst = 1'b1;
          @(posedge clk); #2;
          rst = 1'b0;
          u_if.rx = 1'b1;
          return;
        end
        do_tick(call == ack_call);
      end
    end
    u_if.rx = 1'b1;
    if (!stop) idle_ticks(12);
  endtask

  task automatic false_start();
    u_if.rx = 1'b0;
    do_tick(1'b0);
    do_tick(1'b0);
    idle_ticks(10);
  endtask

  // frame-level reference: what the holding register and flags become
  task automatic model_ack();
    m_dv = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop, input int ack_call);
    bit coinc;
    coinc = (ack_call == 87);
    if (ack_call > 0 && ack_call < 87) model_ack();
    if (!CHECK || stop) begin
      if (!m_dv || coinc) begin
        m_bus = d;
        m_dv  = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
      if (coinc) begin m_fe = 1'b0; m_ov = 1'b0; end
    end else begin
      if (coinc) begin m_dv = 1'b0; m_ov = 1'b0; end
      m_fe = 1'b1;
    end
    if (ack_call > 87) model_ack();
  endtask

  task automatic run_op(input int op, input logic [7:0] d, input bit stop, input int ack_call);
    case (op)
      OP_FRAME: send_frame(d, stop, ack_call, -1);
      OP_ACK:   pulse_ack();
      default:  false_start();
    endcase
  endtask

  vec_t tbl[14];

  initial begin
    rst          = 1'b1;
    u_if.rx      = 1'b1;
    u_if.tick_in = 1'b0;
    u_if.rd_ack  = 1'b0;

    tbl[0]  = '{OP_FRAME, 8'hA5, 1'b1, 0,  8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{OP_ACK,   8'h00, 1'b1, 0,  8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{OP_FALSE, 8'h00, 1'b1, 0,  8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{OP_FRAME, 8'h3C, 1'b0, 0,  CHECK ? 8'hA5 : 8'h3C, !CHECK, CHECK, 1'b0};
    tbl[4]  = '{OP_ACK,   8'h00, 1'b1, 0,  CHECK ? 8'hA5 : 8'h3C, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_FRAME, 8'h11, 1'b1, 0,  8'h11, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{OP_FRAME, 8'h22, 1'b1, 0,  8'h11, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{OP_ACK,   8'h00, 1'b1, 0,  8'h11, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_FRAME, 8'h11, 1'b1, 0,  8'h11, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{OP_FRAME, 8'h22, 1'b1, 87, 8'h22, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{OP_ACK,   8'h00, 1'b1, 0,  8'h22, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{OP_FRAME, 8'h00, 1'b1, 89, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{OP_FRAME, 8'hFF, 1'b1, 89, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{OP_FRAME, 8'h55, 1'b1, 89, 8'h55, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #2;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle_ticks(3);

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].d, tbl[i].stop, tbl[i].ack_call);
      check_all($sformatf("vec%0d", i), tbl[i].eb, tbl[i].edv, tbl[i].efe, tbl[i].eov);
    end

    // fill and overrun, then reset during data bit 4 of 0xFF
    send_frame(8'h77, 1'b1, 0, -1);
    send_frame(8'h88, 1'b1, 0, -1);
    check_all("pre_rst", 8'h77, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 0, 5);
    check_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    idle_ticks(20);
    check_all("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 0, -1);
    check_all("after_rst_frame", 8'h0F, 1'b1, 1'b0, 1'b0);

    m_bus = 8'h0F; m_dv = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    for (int i = 0; i < 24; i++) begin
      int         sel, op, ack_call;
      logic [7:0] d;
      bit         stop;
      sel  = int'($urandom_range(0, 9));
      op   = (sel == 0) ? OP_ACK : (sel == 1) ? OP_FALSE : OP_FRAME;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 3))
        0:       ack_call = 0;
        1:       ack_call = 40;
        2:       ack_call = 87;
        default: ack_call = 89;
      endcase
      if (op == OP_FRAME)    model_frame(d, stop, ack_call);
      else if (op == OP_ACK) model_ack();
      run_op(op, d, stop, ack_call);
      check_all($sformatf("rnd%0d", i), m_bus, m_dv, m_fe, m_ov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter TICKS_PER_BIT, default 9, baud ticks per serial bit period.
REQ-002 Parameter SAMPLE_TICK, default 4, tick index within a bit period at which the line is sampled.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick_in  input  1  baud tick enable; one-clk-wide pulse, same tick source as the serial transmitter.
REQ-006 rx  input  1  serial line; idles high.
REQ-007 rd_ack  input  1  consumer acknowledge; one-clk pulse clears data_valid.
REQ-008 bus  output  8  last accepted byte, bit 0 received first.
REQ-009 data_valid  output  1  bus holds an unread byte.
REQ-010 frame_err  output  1  sticky framing-error flag.
REQ-011 overrun  output  1  sticky overrun flag.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-013 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each TICKS_PER_BIT ticks long; no parity.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: on synchronized rx = 0, go to START with tick counter cleared; no tick required to leave IDLE.
REQ-016 START: count ticks; at count SAMPLE_TICK, if rx = 1 the start is false and the FSM returns to IDLE with no flag change; if rx = 0, clear counter and bit index and go to DATA.
REQ-017 DATA: counter counts 0..TICKS_PER_BIT-1 on tick_in and wraps at TICKS_PER_BIT-1; on each wrap, sample rx into shift bit [index] and increment index; after index 7 is sampled, go to STOP.
REQ-018 STOP: on wrap, sample rx; a sampled 1 is a valid frame; a sampled 0 sets frame_err, discards the byte, and the FSM waits in STOP until rx = 1 before going to IDLE.
REQ-019 Valid frame with data_valid = 0: bus loads the byte and data_valid = 1 on the following clk; the FSM returns to IDLE the same cycle.
REQ-020 Valid frame with data_valid = 1 and no rd_ack that cycle: bus is unchanged, the new byte is dropped, and overrun is set.
REQ-021 Valid frame coinciding with rd_ack: the new byte loads, data_valid stays 1, and no overrun.
REQ-022 rd_ack with data_valid = 1 SHALL clear data_valid, frame_err and overrun on the next clk; rd_ack with data_valid = 0 clears the flags only.
REQ-023 Counter and index SHALL advance only on cycles with tick_in = 1; bus is stable whenever data_valid = 1.

Reset
REQ-024 rst SHALL force, asynchronously: FSM to IDLE, counter and index to 0, synchronizer flops to 1, bus = 8'h00, data_valid = 0, frame_err = 0, overrun = 0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no output change beyond the reset values; after release, the receiver resynchronizes on the next falling edge.

Configuration
REQ-026 Macro RECEIVER_FRAME_CHECK_EN: when defined, the stop bit is checked as in REQ-018.
REQ-027 When RECEIVER_FRAME_CHECK_EN is undefined, the stop bit is not checked: every frame is treated as valid, the frame_err port remains and is tied to 0, and the FSM goes STOP to IDLE on the wrap.

Verification
REQ-028 Byte 8'hA5, 9 ticks/bit, clean stop bit -> bus = 8'hA5, data_valid = 1, frame_err = 0.
REQ-029 rx low for 2 ticks then high -> FSM returns to IDLE, data_valid stays 0, no flags set.
REQ-030 Frame 8'h3C with stop bit 0 -> frame_err = 1, data_valid = 0; with the macro undefined -> bus = 8'h3C, data_valid = 1.
REQ-031 Two frames (8'h11 then 8'h22) with no rd_ack -> bus = 8'h11, overrun = 1; repeat with rd_ack pulsed in the completion cycle of 8'h22 -> bus = 8'h22, overrun = 0.
REQ-032 rst pulsed during data bit 4 of 8'hFF, then frame 8'h0F -> all outputs at reset values after rst; bus = 8'h0F, data_valid = 1 after the second frame.
REQ-033 Back-to-back frames 8'h00, 8'hFF, 8'h55 with rd_ack after each -> three bytes received in order, no flags set.
